// File: rtl/data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_sram_responder
// Brief    : Data-side SRAM-like responder with byte-strobed stores, in-order
//            fixed-latency responses and a bounded number of outstanding requests.
// Revision : 1.0 - initial release
// ============================================================================
module data_sram_responder #(
    parameter int DEPTH_LOG2      = 10,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_sram_addr,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata
);

    localparam int                 c_DEPTH   = 1 << DEPTH_LOG2;
    localparam int                 c_CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_OUTSTANDING);

    logic [31:0]           r_mem [c_DEPTH];
    logic [c_CNT_W-1:0]    r_cnt;
    logic [LATENCY-1:0]    r_valid;
    logic [LATENCY-1:0]    r_is_load;
    logic [31:0]           r_word [LATENCY];
    logic                  w_accept;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_unused;

    assign w_idx    = data_sram_addr[DEPTH_LOG2+1:2];
    assign w_unused = ^{data_sram_size, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

    // A retiring response frees a slot in the same cycle, so addr_ok never depends on req.
    assign data_sram_addr_ok = (r_cnt < c_MAX_CNT) | r_valid[LATENCY-1];
    assign w_accept          = data_sram_req & data_sram_addr_ok;
    assign data_sram_data_ok = r_valid[LATENCY-1];
    assign data_sram_rdata   = (r_valid[LATENCY-1] & r_is_load[LATENCY-1]) ? r_word[LATENCY-1] : 32'd0;

    // Memory is never reset; writes are blocked while reset is held.
    always_ff @(posedge clk) begin
        if (resetn && w_accept && data_sram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wstrb[i]) begin
                    r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid   <= '0;
            r_is_load <= '0;
            r_cnt     <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_word[i] <= 32'd0;
            end
        end else begin
            r_valid[0]   <= w_accept;
            r_is_load[0] <= w_accept & ~data_sram_wr;
            r_word[0]    <= (w_accept && !data_sram_wr) ? r_mem[w_idx] : 32'd0;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i]   <= r_valid[i-1];
                r_is_load[i] <= r_is_load[i-1];
                r_word[i]    <= r_word[i-1];
            end
            case ({w_accept, data_sram_data_ok})
                2'b10:   r_cnt <= r_cnt + c_CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - c_CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_sram_responder
// Brief    : Directed bench; instance a = LATENCY 2 / MAX_OUTSTANDING 2,
//            instance b = LATENCY 3 / MAX_OUTSTANDING 1, sharing one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        a_aok, a_dok, b_aok, b_dok;
    logic [31:0] a_rdata, b_rdata;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(2), .MAX_OUTSTANDING(2)) u_a (
        .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(a_aok),
        .data_sram_data_ok(a_dok), .data_sram_rdata(a_rdata)
    );

    data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(3), .MAX_OUTSTANDING(1)) u_b (
        .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
        .data_sram_size(size), .data_sram_addr(addr), .data_sram_wstrb(wstrb),
        .data_sram_wdata(wdata), .data_sram_addr_ok(b_aok),
        .data_sram_data_ok(b_dok), .data_sram_rdata(b_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic dok, input logic [31:0] rd);
        chk({tag, ".dok"}, 32'(a_dok), 32'(dok));
        chk({tag, ".rdata"}, a_rdata, rd);
    endtask

    // One cycle: drive just after the rising edge, return at the falling edge.
    task automatic go(input logic r, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
        @(posedge clk);
        #1;
        req   = r;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = d;
        size  = 2'd2;
        @(negedge clk);
    endtask

    task automatic idle();
        go(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        resetn = 1'b0;
        req    = 1'b0;
        wr     = 1'b0;
        size   = 2'd0;
        addr   = 32'd0;
        wstrb  = 4'd0;
        wdata  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.a_aok", 32'(a_aok), 32'd1);
        chk_a("rst", 1'b0, 32'd0);
        chk("rst.b_aok", 32'(b_aok), 32'd1);
        resetn = 1'b1;

        // word store then load of the same address
        go(1'b1, 1'b1, 32'h100, 4'hF, 32'hDEADBEEF);
        chk("wl.c0.aok", 32'(a_aok), 32'd1);
        chk_a("wl.c0", 1'b0, 32'd0);
        go(1'b1, 1'b0, 32'h100, 4'h0, 32'd0);
        chk_a("wl.c1", 1'b0, 32'd0);
        idle(); chk_a("wl.c2", 1'b1, 32'd0);
        idle(); chk_a("wl.c3", 1'b1, 32'hDEADBEEF);
        idle(); chk_a("wl.c4", 1'b0, 32'd0);

        // byte strobes merge into an existing word
        go(1'b1, 1'b1, 32'h40, 4'hF, 32'h11223344);
        go(1'b1, 1'b1, 32'h40, 4'h5, 32'hAABBCCDD);
        go(1'b1, 1'b0, 32'h42, 4'h0, 32'd0);
        chk_a("bs.c2", 1'b1, 32'd0);
        idle(); chk_a("bs.c3", 1'b1, 32'd0);
        idle(); chk_a("bs.c4", 1'b1, 32'h11BB33DD);
        idle(); chk_a("bs.c5", 1'b0, 32'd0);

        // back-to-back: 6 stores then 6 loads with req held high
        for (int k = 0; k < 14; k++) begin
            if (k < 6)
                go(1'b1, 1'b1, 32'(32'h200 + 4*k), 4'hF, 32'(32'hA0000000 + k*32'h01010101));
            else if (k < 12)
                go(1'b1, 1'b0, 32'(32'h200 + 4*(k-6)), 4'h0, 32'd0);
            else
                idle();
            if (k < 12) chk($sformatf("b2b.aok.%0d", k), 32'(a_aok), 32'd1);
            chk_a($sformatf("b2b.%0d", k), (k >= 2),
                  (k >= 8) ? 32'(32'hA0000000 + (k-8)*32'h01010101) : 32'd0);
        end
        idle(); chk_a("b2b.end", 1'b0, 32'd0);
        idle();
        idle();

        // backpressure on instance b: preload word 0, then hold req high
        go(1'b1, 1'b1, 32'h0, 4'hF, 32'h12345678);
        chk("bp.pre.aok", 32'(b_aok), 32'd1);
        idle();
        idle();
        idle();
        chk("bp.pre.dok", 32'(b_dok), 32'd1);
        chk("bp.pre.rdata", b_rdata, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k < 7) go(1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
            else       idle();
            chk($sformatf("bp.aok.%0d", k), 32'(b_aok),
                32'(k == 0 || k == 3 || k == 6 || k == 9));
            chk($sformatf("bp.dok.%0d", k), 32'(b_dok), 32'(k == 3 || k == 6 || k == 9));
            chk($sformatf("bp.rdata.%0d", k), b_rdata,
                (k == 3 || k == 6 || k == 9) ? 32'h12345678 : 32'd0);
        end
        idle();
        idle();

        // address wrap and wstrb=0 store
        go(1'b1, 1'b1, 32'h1000, 4'hF, 32'h5A5A5A5A);
        chk_a("wr.c0", 1'b0, 32'd0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
        go(1'b1, 1'b1, 32'h0, 4'h0, 32'hFFFFFFFF);
        chk_a("wr.c2", 1'b1, 32'd0);
        go(1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
        chk_a("wr.c3", 1'b1, 32'h5A5A5A5A);
        idle(); chk_a("wr.c4", 1'b1, 32'd0);
        idle(); chk_a("wr.c5", 1'b1, 32'h5A5A5A5A);

        // reset while responses are in flight
        go(1'b1, 1'b0, 32'h0, 4'h0, 32'd0);
        go(1'b1, 1'b1, 32'h300, 4'hF, 32'hCAFEF00D);
        go(1'b1, 1'b0, 32'h300, 4'h0, 32'd0);
        chk_a("rm.before", 1'b1, 32'h5A5A5A5A);
        resetn = 1'b0;
        req    = 1'b0;
        #1;
        chk_a("rm.during", 1'b0, 32'd0);
        chk("rm.a_aok", 32'(a_aok), 32'd1);
        chk("rm.b_aok", 32'(b_aok), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            idle();
            chk($sformatf("rm.after.a_dok.%0d", k), 32'(a_dok), 32'd0);
            chk($sformatf("rm.after.b_dok.%0d", k), 32'(b_dok), 32'd0);
        end
        go(1'b1, 1'b0, 32'h300, 4'h0, 32'd0);
        idle();
        idle(); chk_a("rm.kept", 1'b1, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_sram_responder.md
# data_sram_responder

Data-side SRAM-like responder: the memory end of the load/store interface whose requests come from the EX stage and whose `data_ok`/`rdata` the MEM stage consumes. It accepts one request per cycle under an `addr_ok` handshake and commits stores with byte strobes at acceptance. Each accepted request returns a one-cycle `data_ok` pulse exactly LATENCY cycles later, strictly in order, with a full 32-bit read word; byte and halfword extraction stays in MEM. It is used in simulation SoC top-levels and as the on-chip data memory for variable-latency pipeline bring-up.

## Interface
Parameters:
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- LATENCY, 2: cycles from acceptance to `data_ok`. Legal range is ≥1.
- MAX_OUTSTANDING, 2: maximum accepted but unanswered requests. Legal range is 1..LATENCY.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = store, 0 = load.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only, `wstrb` governs writes.
- data_sram_addr  in  32  byte address; bits [DEPTH_LOG2+1:2] select the word.
- data_sram_wstrb  in  4  byte enables for stores.
- data_sram_wdata  in  32  store data, already lane-aligned.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with `req`.
- data_sram_data_ok  out  1  response pulse, registered.
- data_sram_rdata  out  32  load word, valid while `data_ok` is high.

## Operation
- Accept condition: `req & addr_ok`. No other input is sampled outside acceptance cycles.
- Outstanding count `cnt`:
  - width is clog2(MAX_OUTSTANDING+1);
  - increments on accept, decrements when `data_ok` is high;
  - when both happen in the same cycle, `cnt` is unchanged.
- `addr_ok` = (`cnt` < MAX_OUTSTANDING) | `data_ok`. It is combinational from registers only, with no path from `req`.
- Store at accept: for each i with `wstrb[i]`=1, write `mem[idx][8i+7:8i]` ← `wdata[8i+7:8i]`.
  - `wstrb` = 0 writes nothing but still produces a response.
- Load at accept: read `mem[idx]` as it stands before that edge. Any store accepted in an earlier cycle is therefore visible.
- Response pipeline: a LATENCY-stage shift register of {valid, is_load, word}.
  - Stage 0 is loaded on accept.
  - Stage LATENCY-1 drives `data_ok` and `rdata`.
- `rdata` = the captured word for loads, and 0 for stores and for idle cycles.
- Address bits above DEPTH_LOG2+1 are ignored, so addresses wrap modulo the memory size. Bits [1:0] are ignored.
- Memory contents are not reset. They are undefined until written, and `$readmemh` preload is allowed in simulation.

## Timing
- Reset (async assert, sync deassert at the board level) takes effect immediately on assertion:
  - `data_ok`=0, `rdata`=0, all pipe valids=0, `cnt`=0, so `addr_ok`=1 directly after reset.
  - Memory is untouched.
- Reset mid-transaction: in-flight responses are dropped and never emitted. Stores already accepted remain written.
- Accept in cycle t → `data_ok`=1 during cycle t+LATENCY only.
- Throughput: with MAX_OUTSTANDING = LATENCY, `req` held high is accepted every cycle. With MAX_OUTSTANDING < LATENCY, `addr_ok` drops once `cnt` reaches the limit, and rises again in the cycle whose `data_ok` retires the oldest request.
- Responses are always in acceptance order.
- Same-address store in cycle t, load in cycle t+1: the load returns the merged new word.

## Test plan
- Reset: hold resetn=0 mid-stream → `data_ok`=0, `rdata`=0, `addr_ok`=1 immediately. No `data_ok` after release for requests accepted before reset.
- Word store/load, LATENCY=2: store 0xDEADBEEF to 0x100 with wstrb=0xF in cycle 0, then load 0x100 in cycle 1.
  - `data_ok` in cycle 2 with `rdata`=0.
  - `data_ok` in cycle 3 with `rdata`=0xDEADBEEF.
- Byte strobes: starting from 0x11223344 at 0x40, store wdata=0xAABBCCDD with wstrb=0b0101, then load 0x42 → `rdata`=0x11BB33DD.
- Back-to-back: 6 loads with `req` held high, MAX_OUTSTANDING=LATENCY=2 → `addr_ok` constantly 1, `data_ok` high in cycles 2..7, data in order.
- Backpressure: MAX_OUTSTANDING=1, LATENCY=3, `req` held high:
  - accepts land in cycles 0, 3, 6;
  - `addr_ok`=0 in cycles 1, 2, 4, 5;
  - `data_ok` in cycles 3, 6, 9.
- Wrap-around: DEPTH_LOG2=10, store 0x5A5A5A5A to 0x1000, then load 0x0 → `rdata`=0x5A5A5A5A. A store with wstrb=0 leaves memory unchanged but still pulses `data_ok`.
